if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC register and presents the current PC to next-PC selection. Loads next-PC selection's result as the new PC each time a fetch completes.
- Drives the instruction-memory request/ack handshake.
- Delivers fetched instructions into the IF/ID pipeline register, with stall buffering and flush on exception/ERET.

Parameters:
- RESET_PC, 32'hBFC0_0000: PC value after reset.
- ADDR_W, 32: PC and memory address width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_IF_next_pc  in  32  next PC from next-PC selection (combinational function of o_IF_current_pc).
- i_flush  in  1  exception answered or ERET in MEM; kills IF/ID contents and the in-flight fetch.
- i_ID_stall  in  1  ID cannot accept a new instruction this cycle.
- o_IF_current_pc  out  32  registered PC of the fetch in progress.
- o_imem_req  out  1  fetch request.
- o_imem_addr  out  32  fetch address (equals o_IF_current_pc).
- i_imem_ack  in  1  read data valid this cycle (may be the same cycle as req).
- i_imem_rdata  in  32  instruction word.
- o_ID_valid  out  1  IF/ID register holds a live instruction.
- o_ID_pc  out  32  PC of the IF/ID instruction.
- o_ID_instr  out  32  instruction word.
- o_ID_exc_adel  out  1  instruction fetch address misaligned (AdEL).

Behaviour:
- Reset (async, immediate):
  - PC = RESET_PC, state = FETCH.
  - flush_pending = 0, skid buffer empty.
  - o_ID_valid = 0, o_ID_pc = 0, o_ID_instr = 0, o_ID_exc_adel = 0.
  - o_imem_req = 0 while reset is high.
- States:
  - FETCH: request outstanding.
  - SKID: word received while ID stalled.
- FETCH:
  - o_imem_req = 1 and o_imem_addr = PC whenever PC[1:0] == 0.
  - Address and request stay stable until ack; a request is never withdrawn.
- Misaligned PC (PC[1:0] != 0):
  - No request is issued.
  - A fetch completion is synthesized in the same cycle with instr = 0 and exc_adel = 1.
- Fetch completion (ack, or misaligned) with no flush active or pending:
  - PC <= i_IF_next_pc.
  - If !o_ID_valid or !i_ID_stall: load the ID register (valid = 1, pc, instr, exc_adel) and stay in FETCH.
  - Otherwise: capture the word into the skid buffer and go to SKID.
- SKID:
  - o_imem_req = 0 and PC holds.
  - When !i_ID_stall: skid -> ID register, then go to FETCH.
- ID drain: !i_ID_stall with no new instruction -> o_ID_valid <= 0.
- Flush (i_flush = 1), IF/ID side:
  - o_ID_valid <= 0 next edge.
  - Skid buffer dropped.
- Flush in SKID or at completion: PC <= i_IF_next_pc (the handler or EPC target), state FETCH.
- Flush in FETCH without ack:
  - redirect_pc <= i_IF_next_pc and flush_pending <= 1.
  - On the later ack, the data is discarded and PC <= redirect_pc.
  - flush_pending clears on that ack.
- A second flush while flush_pending overwrites redirect_pc.
- Flush has priority over stall and over delivery in the same cycle.
- Branch redirect needs no special handling: the delay-slot instruction is already in IF and completes normally. The branch target arrives via i_IF_next_pc at that completion.
- Throughput and latency:
  - With a zero-wait memory (ack same cycle as req), one instruction per cycle.
  - ID outputs are registered, one edge after ack.
- Mid-fetch reset abandons the request. Memory must ignore a late ack arriving after reset, and the stage ignores any ack that arrives while reset is high.

Decomposition:
- Shared package/header entries: RESET_PC default, fetch state encoding (FETCH, SKID), and the AdEL cause code, reusing the existing exception cause defines.
- One sub-module is natural: if_id_skid_reg, holding the IF/ID register plus the single-entry skid buffer with stall/flush.
- PC, redirect_pc, flush_pending and the FSM stay in the top module.

Test Plan:
- Reset release:
  - After reset deasserts, the first req has addr 32'hBFC00000.
  - With ack every cycle and next_pc = pc+4, the ID stream shows pcs BFC00000, BFC00004, BFC00008 on consecutive cycles, all valid.
- Stall:
  - Stall ID for 3 cycles while the word at 0x..08 is acked.
  - The skid holds it, req drops, and the PC stays at next.
  - After release, ID shows 0x..08 and then 0x..0C with no loss or duplicate.
- Flush during wait-state fetch:
  - A fetch at 0x100 with ack delayed 4 cycles; flush at cycle 1 with next_pc = 0xBFC00380.
  - The late ack data is discarded, ID is invalid, and the next req addr is 0xBFC00380.
- Flush and ack in the same cycle: the acked word is not delivered, o_ID_valid = 0, and PC = the flush target.
- Misaligned fetch:
  - next_pc = 0x00000102.
  - No req is issued at that address, and ID shows pc 0x102, instr 0, exc_adel 1.
  - A following flush to 0xBFC00380 resumes fetching.
- Async reset mid-SKID: all outputs return to their reset values immediately (o_ID_valid = 0, PC = RESET_PC), with no dependence on the clock.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: reset vector, fetch FSM
// encoding and the exception cause code raised on a misaligned fetch.
package if_fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    // MIPS Cause.ExcCode for an address error on load or instruction fetch
    localparam logic [4:0]  EXC_CODE_ADEL    = 5'h04;

    typedef enum logic {
        FETCH = 1'b0,
        SKID  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_skid.sv
// IF/ID pipeline register with a single-entry skid buffer. This buffer catches
// a word that completes while ID is stalled on a live instruction.
module if_id_skid_reg #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [31:0]       instr_i,
    input  logic              adel_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [31:0]       instr_o,
    output logic              adel_o
);

    logic              valid_q;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       instr_q;
    logic              adel_q;
    logic              full_q;
    logic [ADDR_W-1:0] skid_pc_q;
    logic [31:0]       skid_instr_q;
    logic              skid_adel_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
            adel_q  <= 1'b0;
            full_q  <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            full_q  <= 1'b0;
        end else if (full_q) begin
            if (!stall_i) begin
                valid_q <= 1'b1;
                pc_q    <= skid_pc_q;
                instr_q <= skid_instr_q;
                adel_q  <= skid_adel_q;
                full_q  <= 1'b0;
            end
        end else if (load_i) begin
            if (!valid_q || !stall_i) begin
                valid_q <= 1'b1;
                pc_q    <= pc_i;
                instr_q <= instr_i;
                adel_q  <= adel_i;
            end else begin
                full_q  <= 1'b1;
            end
        end else if (!stall_i) begin
            valid_q <= 1'b0;
        end
    end

    // Skid payload is only meaningful while full_q is set, so it needs no reset
    always_ff @(posedge clk) begin
        if (load_i && !full_q && valid_q && stall_i) begin
            skid_pc_q    <= pc_i;
            skid_instr_q <= instr_i;
            skid_adel_q  <= adel_i;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign adel_o  = adel_q;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC and drives the imem handshake.
// It feeds the IF/ID register, with stall buffering and exception/ERET flush.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_IF_next_pc,
    input  logic              i_flush,
    input  logic              i_ID_stall,
    output logic [ADDR_W-1:0] o_IF_current_pc,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [31:0]       i_imem_rdata,
    output logic              o_ID_valid,
    output logic [ADDR_W-1:0] o_ID_pc,
    output logic [31:0]       o_ID_instr,
    output logic              o_ID_exc_adel
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] redirect_q, redirect_d;
    logic              pend_q, pend_d;
    logic              misaligned;
    logic              complete;
    logic              deliver;

    assign misaligned = (pc_q[1:0] != 2'b00);
    // A misaligned PC completes immediately without touching memory
    assign complete   = (state_q == FETCH) && (misaligned || i_imem_ack);
    assign deliver    = complete && !pend_q && !i_flush;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        redirect_d = redirect_q;
        pend_d     = pend_q;
        case (state_q)
            FETCH: begin
                if (complete) begin
                    pend_d = 1'b0;
                    pc_d   = (pend_q && !i_flush) ? redirect_q : i_IF_next_pc;
                    if (deliver && o_ID_valid && i_ID_stall) begin
                        state_d = SKID;
                    end
                end else if (i_flush) begin
                    redirect_d = i_IF_next_pc;
                    pend_d     = 1'b1;
                end
            end
            SKID: begin
                if (i_flush) begin
                    pc_d    = i_IF_next_pc;
                    state_d = FETCH;
                end else if (!i_ID_stall) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        redirect_q <= redirect_d;
    end

    assign o_IF_current_pc = pc_q;
    assign o_imem_addr     = pc_q;
    assign o_imem_req      = !reset && (state_q == FETCH) && !misaligned;

    if_id_skid_reg #(
        .ADDR_W (ADDR_W)
    ) u_if_id (
        .clk     (clk),
        .reset   (reset),
        .flush_i (i_flush),
        .stall_i (i_ID_stall),
        .load_i  (deliver),
        .pc_i    (pc_q),
        .instr_i (misaligned ? 32'h0 : i_imem_rdata),
        .adel_i  (misaligned),
        .valid_o (o_ID_valid),
        .pc_o    (o_ID_pc),
        .instr_o (o_ID_instr),
        .adel_o  (o_ID_exc_adel)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: a directed vector table, hand-written corner
// sequences, then random traffic against a queue-based reference model.
module tb_if_fetch_stage;

    localparam logic [31:0] B = 32'hBFC0_0000;
    localparam logic [31:0] H = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] next_pc;
    logic        flush, stall, ack;
    logic [31:0] rdata;
    logic [31:0] cur_pc, imem_addr, id_pc, id_instr;
    logic        imem_req, id_valid, id_adel;

    int          n_vec = 0;
    int          n_err = 0;
    logic        s_req;
    logic [31:0] s_addr;

    if_fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .i_IF_next_pc    (next_pc),
        .i_flush         (flush),
        .i_ID_stall      (stall),
        .o_IF_current_pc (cur_pc),
        .o_imem_req      (imem_req),
        .o_imem_addr     (imem_addr),
        .i_imem_ack      (ack),
        .i_imem_rdata    (rdata),
        .o_ID_valid      (id_valid),
        .o_ID_pc         (id_pc),
        .o_ID_instr      (id_instr),
        .o_ID_exc_adel   (id_adel)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Called just after a rising edge; samples the combinational request mid-cycle
    task automatic cyc(input logic a, input logic st, input logic fl,
                       input logic [31:0] np, input logic [31:0] rd);
        ack = a; stall = st; flush = fl; next_pc = np; rdata = rd;
        #1;
        s_req  = imem_req;
        s_addr = imem_addr;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        a, st, fl;
        logic [31:0] np, rd;
        logic        e_req;
        logic [31:0] e_addr, e_pc;
        logic        e_vld;
        logic [31:0] e_idpc, e_instr;
    } vec_t;

    vec_t tbl[8];

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } ent_t;

    ent_t        q[$];
    ent_t        ent;
    logic [31:0] m_pc, m_redir, np_r, rd_r;
    logic        m_pend, fetching, mis, exp_req, complete, newi, a_r, st_r, fl_r;

    initial begin
        tbl[0] = '{1, 0, 0, B+4,    32'hA000_0000, 1, B,    B+4,  1, B,   32'hA000_0000};
        tbl[1] = '{1, 0, 0, B+8,    32'hA000_0001, 1, B+4,  B+8,  1, B+4, 32'hA000_0001};
        tbl[2] = '{1, 1, 0, B+32'hC, 32'hA000_0002, 1, B+8,  B+32'hC, 1, B+4, 32'hA000_0001};
        tbl[3] = '{0, 1, 0, B+32'h10, 32'h0,        0, 0,    B+32'hC, 1, B+4, 32'hA000_0001};
        tbl[4] = '{1, 1, 0, B+32'h10, 32'hDEAD_0000, 0, 0,   B+32'hC, 1, B+4, 32'hA000_0001};
        tbl[5] = '{0, 0, 0, B+32'h10, 32'h0,        0, 0,    B+32'hC, 1, B+8, 32'hA000_0002};
        tbl[6] = '{1, 0, 0, B+32'h10, 32'hA000_0003, 1, B+32'hC, B+32'h10, 1, B+32'hC, 32'hA000_0003};
        tbl[7] = '{0, 0, 0, B+32'h14, 32'h0,        1, B+32'h10, B+32'h10, 0, 0, 0};

        reset = 1'b1; ack = 0; stall = 0; flush = 0; next_pc = 0; rdata = 0;
        #2;
        chk1("reset_req", imem_req, 1'b0);
        chk1("reset_valid", id_valid, 1'b0);
        chk32("reset_pc", cur_pc, B);
        chk32("reset_idpc", id_pc, 32'h0);
        chk32("reset_instr", id_instr, 32'h0);
        chk1("reset_adel", id_adel, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].a, tbl[i].st, tbl[i].fl, tbl[i].np, tbl[i].rd);
            chk1($sformatf("tbl%0d_req", i), s_req, tbl[i].e_req);
            if (tbl[i].e_req) chk32($sformatf("tbl%0d_addr", i), s_addr, tbl[i].e_addr);
            chk32($sformatf("tbl%0d_pc", i), cur_pc, tbl[i].e_pc);
            chk1($sformatf("tbl%0d_vld", i), id_valid, tbl[i].e_vld);
            if (tbl[i].e_vld) begin
                chk32($sformatf("tbl%0d_idpc", i), id_pc, tbl[i].e_idpc);
                chk32($sformatf("tbl%0d_instr", i), id_instr, tbl[i].e_instr);
            end
        end

        // Flush while a wait-state fetch at 0x100 is outstanding
        cyc(1, 0, 0, 32'h100, 32'hA000_0004);
        chk32("wf_pc", cur_pc, 32'h100);
        cyc(0, 0, 0, 32'h104, 0);
        chk1("wf_req0", s_req, 1'b1);
        chk32("wf_addr0", s_addr, 32'h100);
        cyc(0, 0, 1, H, 0);
        chk1("wf_vld_after_flush", id_valid, 1'b0);
        chk32("wf_pc_hold", cur_pc, 32'h100);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 32'h104, 0);
            chk1("wf_req_held", s_req, 1'b1);
            chk32("wf_addr_held", s_addr, 32'h100);
        end
        cyc(1, 0, 0, 32'h104, 32'hDEAD_BEEF);
        chk1("wf_late_ack_dropped", id_valid, 1'b0);
        chk32("wf_pc_redirect", cur_pc, H);
        cyc(1, 0, 0, H+4, 32'hA000_0005);
        chk1("wf_req_handler", s_req, 1'b1);
        chk32("wf_addr_handler", s_addr, H);
        chk32("wf_idpc_handler", id_pc, H);

        // Flush and ack in the same cycle
        cyc(1, 0, 1, H, 32'hDEAD_0001);
        chk1("fa_vld", id_valid, 1'b0);
        chk32("fa_pc", cur_pc, H);

        // Misaligned fetch produces AdEL without a memory request
        cyc(1, 0, 0, 32'h102, 32'hA000_0006);
        chk32("mis_pc", cur_pc, 32'h102);
        cyc(1, 0, 0, 32'h106, 32'hDEAD_0002);
        chk1("mis_no_req", s_req, 1'b0);
        chk1("mis_vld", id_valid, 1'b1);
        chk32("mis_idpc", id_pc, 32'h102);
        chk32("mis_instr", id_instr, 32'h0);
        chk1("mis_adel", id_adel, 1'b1);
        cyc(0, 0, 1, H, 0);
        chk1("mis_flush_vld", id_valid, 1'b0);
        chk32("mis_flush_pc", cur_pc, H);
        cyc(1, 0, 0, H+4, 32'hA000_0007);
        chk1("mis_resume_req", s_req, 1'b1);
        chk32("mis_resume_addr", s_addr, H);

        // Async reset while the skid buffer is occupied
        cyc(1, 1, 0, H+8, 32'hA000_0008);
        chk32("sk_pc", cur_pc, H+8);
        cyc(0, 1, 0, H+32'hC, 0);
        chk1("sk_no_req", s_req, 1'b0);
        ack = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk1("ar_vld", id_valid, 1'b0);
        chk32("ar_pc", cur_pc, B);
        chk1("ar_req", imem_req, 1'b0);
        chk32("ar_idpc", id_pc, 32'h0);
        chk32("ar_instr", id_instr, 32'h0);
        chk1("ar_adel", id_adel, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk32("ar_ack_ignored_pc", cur_pc, B);
        chk1("ar_ack_ignored_vld", id_valid, 1'b0);
        reset = 1'b0;
        ack = 1'b0;

        // Random traffic against the reference model
        m_pc = B; m_pend = 0; m_redir = 0; q.delete();
        for (int n = 0; n < 3000; n++) begin
            a_r  = ($urandom_range(0, 9) < 6);
            st_r = ($urandom_range(0, 3) == 0);
            fl_r = ($urandom_range(0, 24) == 0);
            rd_r = $urandom;
            if (fl_r) np_r = $urandom_range(0, 1) ? H : ($urandom & 32'hFFFF_FFFC);
            else begin
                case ($urandom_range(0, 15))
                    0:       np_r = m_pc + 2;
                    1:       np_r = $urandom & 32'hFFFF_FFFC;
                    default: np_r = m_pc + 4;
                endcase
            end
            fetching = (q.size() < 2);
            mis      = (m_pc[1:0] != 2'b00);
            exp_req  = fetching && !mis;
            complete = fetching && (mis || a_r);
            newi     = complete && !m_pend && !fl_r;
            ent      = '{pc: m_pc, instr: (mis ? 32'h0 : rd_r), adel: mis};

            cyc(a_r, st_r, fl_r, np_r, rd_r);

            if (fl_r) q.delete();
            else begin
                if (!st_r && q.size() > 0) void'(q.pop_front());
                if (newi) q.push_back(ent);
            end
            if (complete) begin
                m_pc   = (m_pend && !fl_r) ? m_redir : np_r;
                m_pend = 1'b0;
            end else if (fl_r) begin
                if (fetching) begin
                    m_redir = np_r;
                    m_pend  = 1'b1;
                end else begin
                    m_pc = np_r;
                end
            end

            chk1("rnd_req", s_req, exp_req);
            if (exp_req) chk32("rnd_addr", s_addr, ent.pc);
            chk32("rnd_pc", cur_pc, m_pc);
            chk1("rnd_vld", id_valid, (q.size() > 0));
            if (q.size() > 0) begin
                chk32("rnd_idpc", id_pc, q[0].pc);
                chk32("rnd_instr", id_instr, q[0].instr);
                chk1("rnd_adel", id_adel, q[0].adel);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
